ofs_plat_avalon_mem_rdwr_rsp_user_tagger: RTL and testbench

Sits directly downstream of the Avalon rdwr burst mapper, between it and a memory sink that does not return user fields with responses. The block records rd_user/wr_user per accepted burst in in-order tracking FIFOs. It attaches the recorded value to each returning read beat and write ACK. This is what lets the burst mapper's UFLAG_NO_REPLY bit come back on wr_writeresponseuser so the mapper can drop ACKs for injected bursts. Commands and data pass through combinationally; the only added constraint is backpressure when a tracking FIFO is full.

---
 rtl/ofs_plat_avalon_mem_rdwr_rsp_user_tagger.sv | 148 ++++++++++++++
 tb/tb_ofs_plat_avalon_mem_rdwr_rsp_user_tagger.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ofs_plat_avalon_mem_rdwr_rsp_user_tagger.sv
// ofs_plat_avalon_mem_rdwr_rsp_user_tagger: records rd/wr user fields per burst and
// reattaches them to read beats and write ACKs from a sink that returns no user data.
module ofs_plat_avalon_mem_rdwr_rsp_user_tagger #(
   parameter int ADDR_WIDTH      = 64,
   parameter int DATA_WIDTH      = 512,
   parameter int BURST_CNT_WIDTH = 7,
   parameter int USER_WIDTH      = 4,
   parameter int MAX_RD_BURSTS   = 64,
   parameter int MAX_WR_BURSTS   = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       src_rd_read,
   input  logic [ADDR_WIDTH-1:0]      src_rd_address,
   input  logic [BURST_CNT_WIDTH-1:0] src_rd_burstcount,
   input  logic [DATA_WIDTH/8-1:0]    src_rd_byteenable,
   input  logic [USER_WIDTH-1:0]      src_rd_user,
   output logic                       src_rd_waitrequest,
   output logic [DATA_WIDTH-1:0]      src_rd_readdata,
   output logic                       src_rd_readdatavalid,
   output logic [1:0]                 src_rd_response,
   output logic [USER_WIDTH-1:0]      src_rd_readresponseuser,
   input  logic                       src_wr_write,
   input  logic [ADDR_WIDTH-1:0]      src_wr_address,
   input  logic [BURST_CNT_WIDTH-1:0] src_wr_burstcount,
   input  logic [DATA_WIDTH-1:0]      src_wr_writedata,
   input  logic [DATA_WIDTH/8-1:0]    src_wr_byteenable,
   input  logic [USER_WIDTH-1:0]      src_wr_user,
   output logic                       src_wr_waitrequest,
   output logic                       src_wr_writeresponsevalid,
   output logic [1:0]                 src_wr_response,
   output logic [USER_WIDTH-1:0]      src_wr_writeresponseuser,
   output logic                       snk_rd_read,
   output logic [ADDR_WIDTH-1:0]      snk_rd_address,
   output logic [BURST_CNT_WIDTH-1:0] snk_rd_burstcount,
   output logic [DATA_WIDTH/8-1:0]    snk_rd_byteenable,
   output logic [USER_WIDTH-1:0]      snk_rd_user,
   input  logic                       snk_rd_waitrequest,
   input  logic [DATA_WIDTH-1:0]      snk_rd_readdata,
   input  logic                       snk_rd_readdatavalid,
   input  logic [1:0]                 snk_rd_response,
   output logic                       snk_wr_write,
   output logic [ADDR_WIDTH-1:0]      snk_wr_address,
   output logic [BURST_CNT_WIDTH-1:0] snk_wr_burstcount,
   output logic [DATA_WIDTH-1:0]      snk_wr_writedata,
   output logic [DATA_WIDTH/8-1:0]    snk_wr_byteenable,
   output logic [USER_WIDTH-1:0]      snk_wr_user,
   input  logic                       snk_wr_waitrequest,
   input  logic                       snk_wr_writeresponsevalid,
   input  logic [1:0]                 snk_wr_response
);
   localparam int RPW = $clog2(MAX_RD_BURSTS);
   localparam int WPW = $clog2(MAX_WR_BURSTS);
   localparam int RCW = RPW + 1;
   localparam int WCW = WPW + 1;
   logic [USER_WIDTH-1:0]      rd_user_mem [MAX_RD_BURSTS];
   logic [BURST_CNT_WIDTH-1:0] rd_bc_mem   [MAX_RD_BURSTS];
   logic [USER_WIDTH-1:0]      wr_user_mem [MAX_WR_BURSTS];
   logic [RPW-1:0]             rd_wptr_q, rd_rptr_q;
   logic [WPW-1:0]             wr_wptr_q, wr_rptr_q;
   logic [RCW-1:0]             rd_count_q, rd_count_d;
   logic [WCW-1:0]             wr_count_q, wr_count_d;
   logic [BURST_CNT_WIDTH-1:0] rd_beat_q, rd_beat_d, wr_rem_q, wr_rem_d;
   logic                       wr_sop_q, wr_sop_d;
   logic rd_full, rd_empty, rd_push, rd_pop, rd_valid;
   logic wr_full, wr_empty, wr_block, wr_acc, wr_push, wr_pop, wr_ack;
   assign snk_rd_address    = src_rd_address;
   assign snk_rd_burstcount = src_rd_burstcount;
   assign snk_rd_byteenable = src_rd_byteenable;
   assign snk_rd_user       = src_rd_user;
   assign src_rd_readdata   = snk_rd_readdata;
   assign src_rd_response   = snk_rd_response;
   assign snk_wr_address    = src_wr_address;
   assign snk_wr_burstcount = src_wr_burstcount;
   assign snk_wr_writedata  = src_wr_writedata;
   assign snk_wr_byteenable = src_wr_byteenable;
   assign snk_wr_user       = src_wr_user;
   assign src_wr_response   = snk_wr_response;
   // Handshakes are gated by reset so the async reset holds both sides idle.
   always_comb begin
      rd_full                 = rd_count_q == RCW'(MAX_RD_BURSTS);
      rd_empty                = rd_count_q == '0;
      src_rd_waitrequest      = reset || snk_rd_waitrequest || rd_full;
      snk_rd_read             = src_rd_read && !rd_full && !reset;
      rd_push                 = snk_rd_read && !snk_rd_waitrequest;
      rd_valid                = snk_rd_readdatavalid && !reset;
      src_rd_readdatavalid    = rd_valid;
      src_rd_readresponseuser = rd_empty ? '0 : rd_user_mem[rd_rptr_q];
      rd_pop                  = rd_valid && !rd_empty && (rd_beat_q + 1'b1 == rd_bc_mem[rd_rptr_q]);
      rd_beat_d               = rd_pop ? '0 : (rd_valid && !rd_empty) ? rd_beat_q + 1'b1 : rd_beat_q;
      rd_count_d              = rd_count_q + RCW'(rd_push) - RCW'(rd_pop);
   end
   // Only SOP beats consume FIFO space, so mid-burst beats never see wr_block.
   always_comb begin
      wr_full                  = wr_count_q == WCW'(MAX_WR_BURSTS);
      wr_empty                 = wr_count_q == '0;
      wr_block                 = wr_sop_q && wr_full;
      src_wr_waitrequest       = reset || snk_wr_waitrequest || wr_block;
      snk_wr_write             = src_wr_write && !wr_block && !reset;
      wr_acc                   = snk_wr_write && !snk_wr_waitrequest;
      wr_push                  = wr_acc && wr_sop_q;
      wr_ack                   = snk_wr_writeresponsevalid && !reset;
      src_wr_writeresponsevalid = wr_ack;
      src_wr_writeresponseuser = wr_empty ? '0 : wr_user_mem[wr_rptr_q];
      wr_pop                   = wr_ack && !wr_empty;
      wr_sop_d                 = !wr_acc ? wr_sop_q : wr_sop_q ? (src_wr_burstcount <= BURST_CNT_WIDTH'(1)) : (wr_rem_q == BURST_CNT_WIDTH'(1));
      wr_rem_d                 = !wr_acc ? wr_rem_q : wr_sop_q ? src_wr_burstcount - 1'b1 : wr_rem_q - 1'b1;
      wr_count_d               = wr_count_q + WCW'(wr_push) - WCW'(wr_pop);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_wptr_q  <= '0;
         rd_rptr_q  <= '0;
         rd_count_q <= '0;
         rd_beat_q  <= '0;
         wr_wptr_q  <= '0;
         wr_rptr_q  <= '0;
         wr_count_q <= '0;
         wr_sop_q   <= 1'b1;
         wr_rem_q   <= '0;
      end else begin
         rd_wptr_q  <= rd_wptr_q + RPW'(rd_push);
         rd_rptr_q  <= rd_rptr_q + RPW'(rd_pop);
         rd_count_q <= rd_count_d;
         rd_beat_q  <= rd_beat_d;
         wr_wptr_q  <= wr_wptr_q + WPW'(wr_push);
         wr_rptr_q  <= wr_rptr_q + WPW'(wr_pop);
         wr_count_q <= wr_count_d;
         wr_sop_q   <= wr_sop_d;
         wr_rem_q   <= wr_rem_d;
      end
   end
   always_ff @(posedge clk) begin
      if (rd_push) begin
         rd_user_mem[rd_wptr_q] <= src_rd_user;
         rd_bc_mem[rd_wptr_q]   <= src_rd_burstcount;
      end
      if (wr_push) wr_user_mem[wr_wptr_q] <= src_wr_user;
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(rd_valid && rd_empty)) else $fatal(1, "read response with empty tracking FIFO");
         assert (!(wr_ack && wr_empty)) else $fatal(1, "write ACK with empty tracking FIFO");
         assert (!(rd_push && src_rd_burstcount == '0)) else $fatal(1, "read burstcount 0");
         assert (!(wr_push && src_wr_burstcount == '0)) else $fatal(1, "write burstcount 0");
      end
   end
endmodule

// File: tb/tb_ofs_plat_avalon_mem_rdwr_rsp_user_tagger.sv
// tb_ofs_plat_avalon_mem_rdwr_rsp_user_tagger: random/directed traffic against a queue-based
// model of per-burst user tagging, with a monitor popping expected responses.
module tb_ofs_plat_avalon_mem_rdwr_rsp_user_tagger;
   localparam int AW = 16, DW = 32, BCW = 7, UW = 4, MR = 4, MW = 4;
   logic clk = 0, reset = 1;
   logic src_rd_read = 0, src_wr_write = 0;
   logic [AW-1:0] src_rd_address = 0, src_wr_address = 0, snk_rd_address, snk_wr_address;
   logic [BCW-1:0] src_rd_burstcount = 1, src_wr_burstcount = 1, snk_rd_burstcount, snk_wr_burstcount;
   logic [DW/8-1:0] src_rd_byteenable = '1, src_wr_byteenable = '1, snk_rd_byteenable, snk_wr_byteenable;
   logic [UW-1:0] src_rd_user = 0, src_wr_user = 0, snk_rd_user, snk_wr_user;
   logic [UW-1:0] src_rd_readresponseuser, src_wr_writeresponseuser;
   logic [DW-1:0] src_wr_writedata = 0, snk_wr_writedata, src_rd_readdata, snk_rd_readdata = 0;
   logic src_rd_waitrequest, src_wr_waitrequest, src_rd_readdatavalid, src_wr_writeresponsevalid;
   logic snk_rd_read, snk_wr_write;
   logic snk_rd_waitrequest = 0, snk_wr_waitrequest = 0;
   logic snk_rd_readdatavalid = 0, snk_wr_writeresponsevalid = 0;
   logic [1:0] src_rd_response, src_wr_response, snk_rd_response = 0, snk_wr_response = 0;
   int errors = 0, checks = 0, cyc = 0, w;
   logic rand_wait = 0, rand_gap = 0, hold_rd = 0, hold_ack = 0;
   logic [UW-1:0] exp_ru[$], exp_wu[$];
   logic [DW-1:0] exp_rd[$], rd_beats[$];
   int wr_acks[$];

   ofs_plat_avalon_mem_rdwr_rsp_user_tagger #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_CNT_WIDTH(BCW), .USER_WIDTH(UW),
      .MAX_RD_BURSTS(MR), .MAX_WR_BURSTS(MW)
   ) dut (
      .clk(clk), .reset(reset),
      .src_rd_read(src_rd_read), .src_rd_address(src_rd_address), .src_rd_burstcount(src_rd_burstcount),
      .src_rd_byteenable(src_rd_byteenable), .src_rd_user(src_rd_user), .src_rd_waitrequest(src_rd_waitrequest),
      .src_rd_readdata(src_rd_readdata), .src_rd_readdatavalid(src_rd_readdatavalid),
      .src_rd_response(src_rd_response), .src_rd_readresponseuser(src_rd_readresponseuser),
      .src_wr_write(src_wr_write), .src_wr_address(src_wr_address), .src_wr_burstcount(src_wr_burstcount),
      .src_wr_writedata(src_wr_writedata), .src_wr_byteenable(src_wr_byteenable), .src_wr_user(src_wr_user),
      .src_wr_waitrequest(src_wr_waitrequest), .src_wr_writeresponsevalid(src_wr_writeresponsevalid),
      .src_wr_response(src_wr_response), .src_wr_writeresponseuser(src_wr_writeresponseuser),
      .snk_rd_read(snk_rd_read), .snk_rd_address(snk_rd_address), .snk_rd_burstcount(snk_rd_burstcount),
      .snk_rd_byteenable(snk_rd_byteenable), .snk_rd_user(snk_rd_user), .snk_rd_waitrequest(snk_rd_waitrequest),
      .snk_rd_readdata(snk_rd_readdata), .snk_rd_readdatavalid(snk_rd_readdatavalid),
      .snk_rd_response(snk_rd_response),
      .snk_wr_write(snk_wr_write), .snk_wr_address(snk_wr_address), .snk_wr_burstcount(snk_wr_burstcount),
      .snk_wr_writedata(snk_wr_writedata), .snk_wr_byteenable(snk_wr_byteenable), .snk_wr_user(snk_wr_user),
      .snk_wr_waitrequest(snk_wr_waitrequest), .snk_wr_writeresponsevalid(snk_wr_writeresponsevalid),
      .snk_wr_response(snk_wr_response)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Called at a negedge; returns at a negedge with the request dropped.
   task automatic rd_burst(input logic [UW-1:0] u, input int bc, output int waits);
      logic [DW-1:0] d;
      waits = 0;
      src_rd_read = 1; src_rd_user = u; src_rd_burstcount = BCW'(bc); src_rd_address = AW'($urandom);
      #1;
      while (src_rd_waitrequest) begin
         if (++waits > 2000) begin $display("FAIL rd_accept_timeout"); $fatal(1); end
         @(negedge clk); #1;
      end
      chk("rd_passthru", {snk_rd_read, snk_rd_user, snk_rd_burstcount, snk_rd_address},
          {1'b1, u, BCW'(bc), src_rd_address});
      @(posedge clk);
      for (int i = 0; i < bc; i++) begin
         d = DW'($urandom);
         exp_ru.push_back(u); exp_rd.push_back(d); rd_beats.push_back(d);
      end
      @(negedge clk);
      src_rd_read = 0;
   endtask

   // Issues a write burst; with stop_after>0 returns while presenting beat stop_after.
   task automatic wr_burst(input logic [UW-1:0] u, input int bc, input int stop_after, input int dly, output int waits0);
      int wt;
      waits0 = 0;
      for (int b = 0; b < bc; b++) begin
         src_wr_write = 1; src_wr_user = u; src_wr_burstcount = BCW'(bc);
         src_wr_writedata = DW'($urandom); src_wr_address = AW'($urandom);
         if (stop_after != 0 && b == stop_after) return;
         #1; wt = 0;
         while (src_wr_waitrequest) begin
            if (++wt > 2000) begin $display("FAIL wr_accept_timeout"); $fatal(1); end
            @(negedge clk); #1;
         end
         if (b == 0) waits0 = wt;
         chk("wr_passthru", {snk_wr_write, snk_wr_writedata, snk_wr_user}, {1'b1, src_wr_writedata, u});
         @(posedge clk);
         if (b == 0) exp_wu.push_back(u);
         if (b == bc - 1) wr_acks.push_back(cyc + dly);
         @(negedge clk);
      end
      src_wr_write = 0;
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_ru.size() + exp_wu.size() + rd_beats.size() + wr_acks.size()) != 0 && n < 3000) begin
         @(negedge clk); n++;
      end
      chk("drain_done", 64'(n < 3000), 1);
      @(negedge clk);
   endtask

   // Sink model: random waitrequest, read beats in order, ACKs after a per-burst delay.
   initial forever begin
      @(negedge clk);
      snk_rd_waitrequest = rand_wait && ($urandom_range(0, 3) == 0);
      snk_wr_waitrequest = rand_wait && ($urandom_range(0, 3) == 0);
      #1;
      if (!reset && !hold_rd && rd_beats.size() != 0 && (!rand_gap || $urandom_range(0, 2) != 0)) begin
         snk_rd_readdatavalid = 1; snk_rd_readdata = rd_beats.pop_front(); snk_rd_response = 2'($urandom);
      end else snk_rd_readdatavalid = 0;
      if (!reset && !hold_ack && wr_acks.size() != 0 && cyc >= wr_acks[0]) begin
         snk_wr_writeresponsevalid = 1; snk_wr_response = 2'($urandom); void'(wr_acks.pop_front());
      end else snk_wr_writeresponsevalid = 0;
   end

   // Monitor: every response the DUT presents must match the next expected one.
   initial forever begin
      @(negedge clk); #2;
      if (!reset && (src_rd_readdatavalid || snk_rd_readdatavalid))
         chk("rd_valid_fwd", 64'(src_rd_readdatavalid), 64'(snk_rd_readdatavalid));
      if (!reset && (src_wr_writeresponsevalid || snk_wr_writeresponsevalid))
         chk("wr_valid_fwd", 64'(src_wr_writeresponsevalid), 64'(snk_wr_writeresponsevalid));
      if (!reset && src_rd_readdatavalid) begin
         if (exp_ru.size() == 0) begin
            checks++; errors++; $display("FAIL rd_unexpected: beat with no expected entry");
         end else begin
            chk("rd_user", 64'(src_rd_readresponseuser), 64'(exp_ru.pop_front()));
            chk("rd_data", 64'({src_rd_readdata, src_rd_response}), 64'({exp_rd.pop_front(), snk_rd_response}));
         end
      end
      if (!reset && src_wr_writeresponsevalid) begin
         if (exp_wu.size() == 0) begin
            checks++; errors++; $display("FAIL wr_unexpected: ACK with no expected entry");
         end else begin
            chk("wr_user", 64'(src_wr_writeresponseuser), 64'(exp_wu.pop_front()));
            chk("wr_resp", 64'(src_wr_response), 64'(snk_wr_response));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      src_rd_read = 1; src_wr_write = 1;
      #3;
      chk("rst_rd_wait", 64'(src_rd_waitrequest), 1);
      chk("rst_wr_wait", 64'(src_wr_waitrequest), 1);
      chk("rst_snk_req", 64'({snk_rd_read, snk_wr_write}), 0);
      src_rd_read = 0; src_wr_write = 0;
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);
      chk("post_rst_idle_wait", 64'({src_rd_waitrequest, src_wr_waitrequest}), 0);
      // 4-beat write, ACK 10 cycles later
      wr_burst(4'h5, 4, 0, 10, w);
      drain();
      chk("wr_count_empty", 64'(dut.wr_count_q), 0);
      // three single-beat writes, back-to-back ACKs
      wr_burst(4'h1, 1, 0, 3, w);
      wr_burst(4'h2, 1, 0, 3, w);
      wr_burst(4'h3, 1, 0, 3, w);
      drain();
      // write FIFO full: mid-burst beat still accepted, next SOP blocked until an ACK
      hold_ack = 1;
      wr_burst(4'h1, 1, 0, 1, w);
      wr_burst(4'h2, 1, 0, 1, w);
      wr_burst(4'h3, 1, 0, 1, w);
      wr_burst(4'h4, 2, 1, 1, w);
      #1;
      chk("full_midburst_wait", 64'(src_wr_waitrequest), 0);
      chk("full_midburst_write", 64'(snk_wr_write), 1);
      @(posedge clk);
      wr_acks.push_back(cyc + 1);
      @(negedge clk);
      src_wr_user = 4'h5; src_wr_burstcount = 1;
      #1;
      chk("full_sop_wait", 64'(src_wr_waitrequest), 1);
      chk("full_sop_write", 64'(snk_wr_write), 0);
      repeat (3) @(negedge clk);
      #1;
      chk("full_sop_still_wait", 64'(src_wr_waitrequest), 1);
      @(negedge clk);
      hold_ack = 0;
      #2;
      chk("full_ack_cycle_wait", 64'(src_wr_waitrequest), 1);
      @(negedge clk); #1;
      chk("full_after_ack_wait", 64'(src_wr_waitrequest), 0);
      @(posedge clk);
      exp_wu.push_back(4'h5); wr_acks.push_back(cyc + 1);
      @(negedge clk);
      src_wr_write = 0;
      drain();
      // reads A(3 beats) then B(1 beat), with gaps
      rand_gap = 1;
      rd_burst(4'hA, 3, w);
      rd_burst(4'hB, 1, w);
      drain();
      chk("rd_count_empty", 64'(dut.rd_count_q), 0);
      // push and pop in the same cycle at occupancy MR-1
      rand_gap = 0; hold_rd = 1;
      for (int i = 0; i < MR - 1; i++) rd_burst(UW'(i), 1, w);
      hold_rd = 0;
      rd_burst(4'h9, 1, w);
      chk("pushpop_no_wait", 64'(w), 0);
      #1;
      chk("pushpop_count", 64'(dut.rd_count_q), 64'(MR - 1));
      chk("pushpop_rd_wait", 64'(src_rd_waitrequest), 0);
      drain();
      // random concurrent traffic (many times the FIFO depth, so pointers wrap)
      rand_wait = 1; rand_gap = 1;
      fork
         for (int i = 0; i < 40; i++) begin
            rd_burst(UW'($urandom), $urandom_range(1, 4), w);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
         end
         for (int i = 0; i < 40; i++) begin
            wr_burst(UW'($urandom), $urandom_range(1, 4), 0, $urandom_range(0, 6), w);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
         end
      join
      drain();
      chk("rand_counts_empty", 64'({dut.rd_count_q, dut.wr_count_q}), 0);
      // reset during beat 2 of an 8-beat write
      rand_wait = 0; rand_gap = 0;
      wr_burst(4'h7, 8, 1, 1, w);
      #1;
      reset = 1;
      #1;
      chk("midrst_wr_wait", 64'(src_wr_waitrequest), 1);
      chk("midrst_snk_write", 64'(snk_wr_write), 0);
      chk("midrst_rd_wait", 64'(src_rd_waitrequest), 1);
      exp_wu.delete(); exp_ru.delete(); exp_rd.delete(); rd_beats.delete(); wr_acks.delete();
      src_wr_write = 0;
      repeat (2) @(negedge clk);
      reset = 0;
      #1;
      chk("midrst_sop", 64'(dut.wr_sop_q), 1);
      chk("midrst_counts", 64'({dut.rd_count_q, dut.wr_count_q}), 0);
      @(negedge clk);
      wr_burst(4'h3, 2, 0, 2, w);
      drain();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
